// File: rtl/psum_accum_if.sv
// psum_accum_if
//   Stream bundle between the corelet psum output, the accumulation stage and
//   the write-back path. Both directions use a valid/ready handshake.
//   in_valid / in_ready / in_data    : corelet psum vector into the stage
//   out_valid / out_ready / out_data : drained vector toward SRAM write-back
//   Lane i of a vector sits at bits [psum_bw*i +: psum_bw], two's complement.
//   slave  : the accumulation stage side
//   master : the side that feeds psums and sinks drained vectors
interface psum_accum_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [psum_bw*col-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [psum_bw*col-1:0]   out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/psum_accum.sv
// psum_accum
//   Accumulates num_pass kernel passes of corelet psum vectors into a register
//   buffer of depth vectors (per-lane saturating add), then drains the buffer
//   in order, optionally clamping negative lanes to zero.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low; clears control, buffer and outputs
//   start    : begins a tile, only honoured while idle
//   num_pass : passes per tile, latched on start (0 means 1)
//   relu_en  : latched on start; zero negative lanes when draining
//   bus      : psum input stream and drained output stream (slave side)
//   busy     : high whenever a tile is in progress
//   done     : one-cycle pulse after the final drained vector
module psum_accum #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           num_pass,
    input  logic                 relu_en,
    psum_accum_if.slave          bus,
    output logic                 busy,
    output logic                 done
);
    localparam int aw    = (depth > 1) ? $clog2(depth) : 1;
    localparam int vec_w = psum_bw * col;

    localparam logic [aw-1:0]              last_idx = aw'(depth - 1);
    localparam logic signed [psum_bw-1:0]  lane_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0]  lane_min = {1'b1, {(psum_bw-1){1'b0}}};

    typedef logic [vec_w-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t       state_q, state_d;
    logic [aw-1:0] idx;
    logic [3:0]   pass;
    logic [3:0]   npass_q;
    logic         relu_q;
    logic         done_q;
    vec_t         acc_mem [depth];

    logic         in_fire;
    logic         out_fire;
    logic         last_pass;

    // One extra bit holds the exact lane sum; a disagreement between the two
    // top bits means the result left the lane range, and the top bit gives
    // the direction of the overflow.
    function automatic logic signed [psum_bw-1:0] sat_add(
        input logic signed [psum_bw-1:0] a,
        input logic signed [psum_bw-1:0] b
    );
        logic signed [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            return s[psum_bw] ? lane_min : lane_max;
        return s[psum_bw-1:0];
    endfunction

    function automatic vec_t accum_vec(input vec_t old_v, input vec_t new_v);
        vec_t r;
        r = '0;
        for (int l = 0; l < col; l++)
            r[l*psum_bw +: psum_bw] = sat_add(old_v[l*psum_bw +: psum_bw],
                                              new_v[l*psum_bw +: psum_bw]);
        return r;
    endfunction

    function automatic vec_t relu_vec(input vec_t v);
        vec_t r;
        r = v;
        for (int l = 0; l < col; l++)
            if (v[l*psum_bw + psum_bw - 1])
                r[l*psum_bw +: psum_bw] = '0;
        return r;
    endfunction

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_pass = (pass == npass_q - 4'd1);

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = ACCUM;
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (in_fire && idx == last_idx && last_pass)
                    state_d = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                if (out_fire && idx == last_idx)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx     <= '0;
            pass    <= '0;
            npass_q <= 4'd1;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < depth; i++)
                acc_mem[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= out_fire && (idx == last_idx);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        pass    <= '0;
                        npass_q <= (num_pass == 4'd0) ? 4'd1 : num_pass;
                        relu_q  <= relu_en;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        // Pass 0 overwrites, so stale contents never need clearing.
                        acc_mem[idx] <= (pass == 4'd0) ? bus.in_data
                                                       : accum_vec(acc_mem[idx], bus.in_data);
                        // depth is a power of two, so idx wraps to 0 by itself,
                        // which also leaves it at 0 for the drain.
                        idx <= idx + 1'b1;
                        if (idx == last_idx)
                            pass <= pass + 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_fire)
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = bus.out_valid ? (relu_q ? relu_vec(acc_mem[idx]) : acc_mem[idx])
                                        : '0;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum
//   Randomized bench for psum_accum (depth 4, 8 lanes of 16 bits). A plain
//   integer model of the tile (overwrite on the first pass, clamped adds
//   afterwards, optional ReLU on drain) predicts every drained vector.
module tb_psum_accum;
    localparam int BW    = 16;
    localparam int COL   = 8;
    localparam int DEPTH = 4;
    localparam int VW    = BW * COL;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_pass;
    logic       relu_en;
    logic       busy;
    logic       done;

    psum_accum_if #(.psum_bw(BW), .col(COL)) bus ();

    psum_accum #(.psum_bw(BW), .col(COL), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_pass (num_pass),
        .relu_en  (relu_en),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] vecs [$];
    logic [VW-1:0] exp_v [DEPTH];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [VW-1:0] pack_all(input int v);
        logic [VW-1:0] r;
        r = '0;
        for (int l = 0; l < COL; l++)
            r[l*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        r = '0;
        for (int l = 0; l < COL; l++)
            r[l*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    function automatic int lane_of(input logic [VW-1:0] w, input int l);
        logic signed [BW-1:0] s;
        s = w[l*BW +: BW];
        return int'(s);
    endfunction

    // Tile model: vector k lands in entry k % DEPTH during pass k / DEPTH.
    task automatic build_model(input bit relu);
        int acc [DEPTH][COL];
        int s;
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++)
                acc[e][l] = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            for (int l = 0; l < COL; l++) begin
                if (k / DEPTH == 0) begin
                    acc[k % DEPTH][l] = lane_of(vecs[k], l);
                end else begin
                    s = acc[k % DEPTH][l] + lane_of(vecs[k], l);
                    if (s > 32767)  s = 32767;
                    if (s < -32768) s = -32768;
                    acc[k % DEPTH][l] = s;
                end
            end
        end
        for (int e = 0; e < DEPTH; e++) begin
            exp_v[e] = '0;
            for (int l = 0; l < COL; l++)
                exp_v[e][l*BW +: BW] = BW'((relu && acc[e][l] < 0) ? 0 : acc[e][l]);
        end
    endtask

    // Runs one tile from the current negedge using the vectors in vecs.
    // abort_at >= 0 pulls reset low when that many outputs have drained.
    task automatic run_tile(input int np, input bit relu, input int gap_pct,
                            input int stall_pct, input int abort_at);
        int np_eff;
        int sent;
        int recv;
        int budget;
        np_eff = (np == 0) ? 1 : np;
        sent = 0;
        recv = 0;
        build_model(relu);

        chk("busy_before_start", VW'(busy), VW'(0));
        start    = 1'b1;
        num_pass = np[3:0];
        relu_en  = relu;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", VW'(busy), VW'(1));
        chk("done_after_start", VW'(done), VW'(0));

        budget = 0;
        while (sent < DEPTH * np_eff) begin
            if (budget++ > 5000) begin
                chk("in_timeout", VW'(0), VW'(1));
                return;
            end
            chk("in_ready", VW'(bus.in_ready), VW'(1));
            relu_en  = 1'($urandom);
            num_pass = 4'($urandom);
            start    = ($urandom % 6 == 0);
            if ($urandom % 100 < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = {4{$urandom}};
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = vecs[sent];
            end
            @(negedge clk);
            if (bus.in_valid) sent++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("in_ready_drain", VW'(bus.in_ready), VW'(0));

        budget = 0;
        while (recv < DEPTH) begin
            if (budget++ > 5000) begin
                chk("out_timeout", VW'(0), VW'(1));
                return;
            end
            if (recv == abort_at) begin
                reset = 1'b0;
                #1;
                chk("rst_out_valid", VW'(bus.out_valid), VW'(0));
                chk("rst_out_data", bus.out_data, '0);
                chk("rst_busy", VW'(busy), VW'(0));
                chk("rst_in_ready", VW'(bus.in_ready), VW'(0));
                @(negedge clk);
                reset         = 1'b1;
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b0;
                start         = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_done", VW'(done), VW'(0));
                    chk("rst_idle", VW'(busy), VW'(0));
                end
                return;
            end
            chk("out_valid", VW'(bus.out_valid), VW'(1));
            chk("done_early", VW'(done), VW'(0));
            bus.in_valid  = 1'($urandom);
            bus.in_data   = {4{$urandom}};
            start         = ($urandom % 4 == 0);
            bus.out_ready = ($urandom % 100 >= stall_pct);
            chk("out_data", bus.out_data, exp_v[recv]);
            @(negedge clk);
            if (bus.out_ready) recv++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        start         = 1'b0;
        chk("done_pulse", VW'(done), VW'(1));
        chk("busy_end", VW'(busy), VW'(0));
        chk("out_valid_end", VW'(bus.out_valid), VW'(0));
    endtask

    initial begin
        logic [VW-1:0] w;
        reset         = 1'b0;
        start         = 1'b0;
        num_pass      = 4'd0;
        relu_en       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", VW'(bus.in_ready), VW'(0));
        chk("reset_out_valid", VW'(bus.out_valid), VW'(0));
        chk("reset_out_data", bus.out_data, '0);
        chk("reset_busy", VW'(busy), VW'(0));
        chk("reset_done", VW'(done), VW'(0));
        reset = 1'b1;

        // input offered while idle is ignored
        bus.in_valid = 1'b1;
        bus.in_data  = pack_all(77);
        repeat (2) begin
            @(negedge clk);
            chk("idle_in_ready", VW'(bus.in_ready), VW'(0));
            chk("idle_busy", VW'(busy), VW'(0));
        end
        bus.in_valid = 1'b0;

        // single pass, ramp 1..4, no stalls
        vecs.delete();
        for (int k = 0; k < DEPTH; k++) vecs.push_back(pack_all(k + 1));
        run_tile(1, 1'b0, 0, 0, -1);

        // three passes of 100
        vecs.delete();
        for (int k = 0; k < 3 * DEPTH; k++) vecs.push_back(pack_all(100));
        run_tile(3, 1'b0, 0, 0, -1);

        // num_pass 0 acts as one pass
        vecs.delete();
        for (int k = 0; k < DEPTH; k++) vecs.push_back(rand_vec());
        run_tile(0, 1'b0, 10, 20, -1);

        // saturation in both directions and a plain signed sum
        vecs.delete();
        for (int k = 0; k < 2 * DEPTH; k++) begin
            w = rand_vec();
            w[0 +: BW]    = BW'(30000);
            w[BW +: BW]   = BW'(-30000);
            w[2*BW +: BW] = (k < DEPTH) ? BW'(5) : BW'(-7);
            vecs.push_back(w);
        end
        run_tile(2, 1'b0, 0, 0, -1);

        // ReLU on drain
        vecs.delete();
        for (int k = 0; k < DEPTH; k++) begin
            w = rand_vec();
            w[0 +: BW]    = BW'(-5);
            w[BW +: BW]   = BW'(0);
            w[2*BW +: BW] = BW'(7);
            w[3*BW +: BW] = BW'(-32768);
            vecs.push_back(w);
        end
        run_tile(1, 1'b1, 0, 0, -1);

        // randomized tiles with input gaps and output backpressure
        for (int t = 0; t < 8; t++) begin
            int np;
            np = $urandom_range(0, 5);
            vecs.delete();
            for (int k = 0; k < DEPTH * ((np == 0) ? 1 : np); k++) vecs.push_back(rand_vec());
            run_tile(np, 1'($urandom), 30, 50, -1);
        end

        // reset during drain, then a fresh single-pass tile
        vecs.delete();
        for (int k = 0; k < 2 * DEPTH; k++) vecs.push_back(rand_vec());
        run_tile(2, 1'b0, 20, 0, 2);
        vecs.delete();
        for (int k = 0; k < DEPTH; k++) vecs.push_back(pack_all(9));
        run_tile(1, 1'b0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Output-side accumulation stage placed directly downstream of `corelet` inside `core`. It consumes the corelet's per-cycle vector of `col` signed partial sums and accumulates them over `num_pass` kernel passes into an on-block register buffer of `depth` output vectors. It then drains the finished vectors, with optional ReLU, to the write-back path toward the 32b x 2048 SRAM. It replaces ad-hoc psum read-modify-write through SRAM with a single handshaked stage.

## Interface
- `psum_bw`, 16, width of one signed partial sum lane
- `col`, 8, lanes per vector (matches corelet columns)
- `depth`, 16, output vectors buffered per tile (power of 2, >= 2)
- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset; clears all state while low
- `start`  input  1  begin a tile; sampled only in IDLE
- `num_pass`  input  4  passes to accumulate; latched on `start`; 0 treated as 1
- `relu_en`  input  1  latched on `start`; 1 = clamp negative lanes to 0 on drain
- `in_valid`  input  1  corelet psum vector valid
- `in_ready`  output  1  stage accepts a vector this cycle
- `in_data`  input  psum_bw*col  lane i at bits [psum_bw*i +: psum_bw], two's complement
- `out_valid`  output  1  drained vector valid
- `out_ready`  input  1  downstream accepts the drained vector
- `out_data`  output  psum_bw*col  drained vector, same lane packing
- `busy`  output  1  state != IDLE
- `done`  output  1  one-cycle pulse after the last drained vector

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE: `in_ready`=0, `out_valid`=0. On `start`=1: latch `num_pass` (0->1) and `relu_en`, clear `idx` and `pass`, go to ACCUM.
- ACCUM: `in_ready`=1. An input transfer occurs when `in_valid`&&`in_ready`. On transfer:
  - pass 0: `buf[idx]` <= `in_data`, overwrite; no clear of stale contents needed.
  - pass > 0: per lane `buf[idx]` <= sat(`buf[idx]` + `in_data`).
  - `idx` increments. At `idx`=depth-1 it wraps to 0 and `pass` increments. On the wrap of the final pass (`pass`=num_pass-1), go to DRAIN with `idx`=0.
- Saturation: psum_bw+1-bit signed sum per lane, clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Lanes are independent; no carry between lanes.
- DRAIN: `out_valid`=1. `out_data` = `buf[idx]`, each lane replaced by 0 if `relu_en` and the lane is negative. An output transfer occurs when `out_valid`&&`out_ready`; `idx` then increments. The transfer at `idx`=depth-1 returns to IDLE and asserts `done` on the next cycle.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is ignored; no data is consumed.
- Reset low, at any time including mid-tile: state IDLE, `idx`=`pass`=0, all buffer entries 0, all outputs 0. The tile is abandoned and no `done` is generated.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- `start` sampled at edge E: `busy` and `in_ready` go high in the cycle after E.
- One input vector per cycle at full throughput; no bubbles at pass wrap.
- Last input transfer at edge E: DRAIN with `out_valid`=1 in the cycle after E, presenting the fully accumulated `buf[0]`.
- `out_data` is combinational from the buffer and latched `relu_en`. It is stable while `out_valid`=1 and `out_ready`=0.
- One output per cycle while `out_ready`=1. Final output transfer at edge E: `busy`=0 and `done`=1 in the cycle after E only. A `start` in that same cycle is accepted.
- Total tile latency with no stalls: depth*num_pass input cycles + depth drain cycles.

## Test plan
- depth=4, num_pass=1, relu_en=0, inputs all lanes = 1,2,3,4; out_ready=1 -> outputs 1,2,3,4 on consecutive cycles starting the cycle after the 4th input; `done` pulses once.
- num_pass=3, every input all lanes = 100 -> every drained lane = 300. Also num_pass=0 -> behaves as 1 pass.
- Saturation: 2 passes, lane 0 = 30000 then 30000 -> 32767; lane 1 = -30000 twice -> -32768; lane 2 = 5 then -7 -> -2.
- relu_en=1, lanes {-5, 0, 7, -32768, ...} -> {0, 0, 7, 0, ...}. Toggling `relu_en` mid-tile has no effect.
- Backpressure: `out_ready` random 50% and `in_valid` random gaps -> no lost or duplicated vectors, `out_data` held while stalled, `start` during ACCUM ignored.
- Reset low during DRAIN with idx=2 -> outputs 0 immediately, buffer cleared, no `done`. A following tile of 1 pass with inputs 9 -> output 9.
